// File: rtl/alu_bist_ctrl.sv
// BIST driver/checker for the RV32I ALU: LFSR operands, cycling ALUControl, MISR compaction.
// Optional ALU_BIST_FAULT_INJECT_EN adds inject_fault, which flips response bit 0 before compaction.
module alu_bist_ctrl #(
    parameter int          NUM_VECTORS      = 256,
    parameter logic [31:0] LFSR_SEED_A      = 32'hACE1_2468,
    parameter logic [31:0] LFSR_SEED_B      = 32'h1357_9BDF,
    parameter logic [31:0] MISR_SEED        = 32'hFFFF_FFFF,
    parameter logic [31:0] GOLDEN_SIGNATURE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [31:0] signature,
    output logic [31:0] alu_A,
    output logic [31:0] alu_B,
    output logic [3:0]  alu_ctrl,
`ifdef ALU_BIST_FAULT_INJECT_EN
    input  logic        inject_fault,
`endif
    input  logic [31:0] alu_Result,
    input  logic        alu_Carry,
    input  logic        alu_OverFlow,
    input  logic        alu_Zero,
    input  logic        alu_Negative
);

    localparam logic [31:0] SEED_A    = (LFSR_SEED_A == 32'h0) ? 32'h1 : LFSR_SEED_A;
    localparam logic [31:0] SEED_B    = (LFSR_SEED_B == 32'h0) ? 32'h1 : LFSR_SEED_B;
    localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] LFSR_POLY = 32'h0040_0007;
    localparam logic [15:0] LAST_CNT  = 16'(NUM_VECTORS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      state_q;
    logic [31:0] lfsr_a_q, lfsr_b_q, sig_q;
    logic [31:0] lfsr_a_d, lfsr_b_d, sig_d, resp;
    logic [15:0] cnt_q;
    logic [3:0]  op_q;
    logic        busy_q, done_q, pass_q;

    always_comb begin
        resp = alu_Result ^ {28'b0, alu_Carry, alu_OverFlow, alu_Zero, alu_Negative};
`ifdef ALU_BIST_FAULT_INJECT_EN
        resp[0] = resp[0] ^ inject_fault;
`endif
        sig_d    = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? MISR_POLY : 32'h0) ^ resp;
        lfsr_a_d = {lfsr_a_q[30:0], 1'b0} ^ (lfsr_a_q[31] ? LFSR_POLY : 32'h0);
        lfsr_b_d = {lfsr_b_q[30:0], 1'b0} ^ (lfsr_b_q[31] ? LFSR_POLY : 32'h0);
    end

    // Stimulus comes straight from the registers so the ALU sees vector k during cycle k.
    assign alu_A     = (state_q == S_RUN) ? lfsr_a_q : 32'h0;
    assign alu_B     = (state_q == S_RUN) ? lfsr_b_q : 32'h0;
    assign alu_ctrl  = (state_q == S_RUN) ? op_q : 4'h0;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = sig_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            sig_q    <= MISR_SEED;
            cnt_q    <= 16'h0;
            op_q     <= 4'h0;
            lfsr_a_q <= SEED_A;
            lfsr_b_q <= SEED_B;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q  <= S_RUN;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        pass_q   <= 1'b0;
                        sig_q    <= MISR_SEED;
                        cnt_q    <= 16'h0;
                        op_q     <= 4'h0;
                        lfsr_a_q <= SEED_A;
                        lfsr_b_q <= SEED_B;
                    end
                end
                S_RUN: begin
                    sig_q    <= sig_d;
                    lfsr_a_q <= lfsr_a_d;
                    lfsr_b_q <= lfsr_b_d;
                    op_q     <= (op_q == 4'd9) ? 4'd0 : op_q + 4'd1;
                    cnt_q    <= cnt_q + 16'd1;
                    if (cnt_q == LAST_CNT) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (sig_d == GOLDEN_SIGNATURE);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Bench for alu_bist_ctrl: behavioural ALU + spec-level model, a 256-vector and a 12-vector instance.
module tb_alu_bist_ctrl;

    localparam int          NVA = 256;
    localparam int          NVB = 12;
    localparam logic [31:0] SA  = 32'hACE1_2468;
    localparam logic [31:0] SB  = 32'h1357_9BDF;
    localparam logic [31:0] MS  = 32'hFFFF_FFFF;

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return {x[30:0], 1'b0} ^ (x[31] ? 32'h0040_0007 : 32'h0);
    endfunction

    function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [31:0] d);
        return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C1_1DB7 : 32'h0) ^ d;
    endfunction

    // Reference RV32I ALU: returns {Result, Carry, OverFlow, Zero, Negative}.
    function automatic logic [35:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        logic [32:0] w;
        logic [31:0] r;
        logic cy, ov;
        cy = 1'b0; ov = 1'b0; w = 33'h0;
        case (c)
            4'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; cy = w[32];
                        ov = (a[31] == b[31]) && (r[31] != a[31]); end
            4'd1: begin w = {1'b0, a} + {1'b0, ~b} + 33'd1; r = w[31:0]; cy = w[32];
                        ov = (a[31] != b[31]) && (r[31] != a[31]); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = {31'b0, $signed(a) < $signed(b)};
            4'd6: r = {31'b0, a < b};
            4'd7: r = a << b[4:0];
            4'd8: r = a >> b[4:0];
            default: r = $signed(a) >>> b[4:0];
        endcase
        return {r, cy, ov, (r == 32'h0), r[31]};
    endfunction

    function automatic logic [31:0] model_sig(input int n);
        logic [31:0] a, b, s;
        logic [35:0] r;
        a = SA; b = SB; s = MS;
        for (int k = 0; k < n; k++) begin
            r = alu_f(a, b, 4'(k % 10));
            s = misr_step(s, r[35:4] ^ {28'b0, r[3:0]});
            a = lfsr_step(a);
            b = lfsr_step(b);
        end
        return s;
    endfunction

    localparam logic [31:0] GOLD_A  = model_sig(NVA);
    localparam logic [31:0] SIG_B   = model_sig(NVB);

    logic clk = 1'b0;
    logic rst, st_a, st_b, inj;
    logic busy_a, done_a, pass_a, busy_b, done_b, pass_b;
    logic [31:0] sig_a, opa_a, opb_a, sig_b, opa_b, opb_b;
    logic [3:0]  ctl_a, ctl_b;
    logic [35:0] rsp_a, rsp_b;

    always #5 clk = ~clk;

    assign rsp_a = alu_f(opa_a, opb_a, ctl_a);
    assign rsp_b = alu_f(opa_b, opb_b, ctl_b);

    alu_bist_ctrl #(.NUM_VECTORS(NVA), .GOLDEN_SIGNATURE(GOLD_A)) u_dut_a (
        .clk(clk), .rst(rst), .start(st_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .signature(sig_a), .alu_A(opa_a), .alu_B(opb_a), .alu_ctrl(ctl_a),
`ifdef ALU_BIST_FAULT_INJECT_EN
        .inject_fault(inj),
`endif
        .alu_Result(rsp_a[35:4]), .alu_Carry(rsp_a[3]), .alu_OverFlow(rsp_a[2]),
        .alu_Zero(rsp_a[1]), .alu_Negative(rsp_a[0]));

    // Golden deliberately off by one bit so pass must come out low.
    alu_bist_ctrl #(.NUM_VECTORS(NVB), .GOLDEN_SIGNATURE(SIG_B ^ 32'h1)) u_dut_b (
        .clk(clk), .rst(rst), .start(st_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .signature(sig_b), .alu_A(opa_b), .alu_B(opb_b), .alu_ctrl(ctl_b),
`ifdef ALU_BIST_FAULT_INJECT_EN
        .inject_fault(1'b0),
`endif
        .alu_Result(rsp_b[35:4]), .alu_Carry(rsp_b[3]), .alu_OverFlow(rsp_b[2]),
        .alu_Zero(rsp_b[1]), .alu_Negative(rsp_b[0]));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Spec-level model of instance A, advanced on every rising edge.
    bit          m_ok = 1'b0;
    bit          m_busy, m_done, m_pass;
    logic [31:0] m_sig, m_a, m_b, m_d;
    logic [35:0] m_r;
    int          m_k;

    always @(posedge clk) begin
        if (rst) begin
            m_ok = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_pass = 1'b0;
            m_sig = MS; m_a = SA; m_b = SB; m_k = 0;
        end else if (!m_busy && st_a) begin
            m_busy = 1'b1; m_done = 1'b0; m_pass = 1'b0;
            m_sig = MS; m_a = SA; m_b = SB; m_k = 0;
        end else if (m_busy) begin
            m_r = alu_f(m_a, m_b, 4'(m_k % 10));
            m_d = m_r[35:4] ^ {28'b0, m_r[3:0]};
            m_d[0] = m_d[0] ^ inj;
            m_sig = misr_step(m_sig, m_d);
            m_a = lfsr_step(m_a);
            m_b = lfsr_step(m_b);
            if (m_k == NVA - 1) begin
                m_busy = 1'b0; m_done = 1'b1; m_pass = (m_sig == GOLD_A);
            end
            m_k++;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk1("model_busy", busy_a, m_busy);
            chk1("model_done", done_a, m_done);
            chk("model_sig", sig_a, m_sig);
            chk("model_alu_A", opa_a, m_busy ? m_a : 32'h0);
            chk("model_alu_B", opb_a, m_busy ? m_b : 32'h0);
            chk("model_alu_ctrl", {28'b0, ctl_a}, m_busy ? 32'(m_k % 10) : 32'h0);
            if (m_done) chk1("model_pass", pass_a, m_pass);
        end
    end

    // Runs one start on A; optional fault on vector inj_vec, optional start re-pulse on vector mid_vec.
    task automatic run_a(input int inj_vec, input int mid_vec, output int lat);
        st_a = 1'b1;
        lat = 0;
        forever begin
            @(negedge clk);
            st_a = 1'b0; inj = 1'b0;
            lat++;
            if (lat == 1) chk1("done_drops_after_start", done_a, 1'b0);
            if (lat == 2) begin
                chk("pin_sig_v0", sig_a, 32'h3B06_220F);
                chk("pin_alu_A_v1", opa_a, 32'h5982_48D7);
                chk("pin_alu_B_v1", opb_a, 32'h26AF_37BE);
            end
            if (done_a) break;
            if (lat > 600) begin
                chk1("run_a_timeout", 1'b0, 1'b1);
                break;
            end
            if (lat - 1 == inj_vec) inj = 1'b1;
            if (lat - 1 == mid_vec) st_a = 1'b1;
        end
    endtask

    int lat;
    logic [31:0] s0;

    initial begin
        rst = 1'b1; st_a = 1'b0; st_b = 1'b0; inj = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rst_busy", busy_a, 1'b0);
        chk1("rst_done", done_a, 1'b0);
        chk1("rst_pass", pass_a, 1'b0);
        chk("rst_sig", sig_a, 32'hFFFF_FFFF);
        chk("rst_alu_A", opa_a, 32'h0);
        chk("rst_alu_B", opb_a, 32'h0);
        chk("rst_alu_ctrl", {28'b0, ctl_a}, 32'h0);
        chk("rst_sig_b", sig_b, 32'hFFFF_FFFF);
        rst = 1'b0;

        // 12-vector timing and op sequence
        @(negedge clk);
        st_b = 1'b1;
        @(negedge clk);
        st_b = 1'b0;
        chk("b_alu_A_first", opa_b, 32'hACE1_2468);
        chk("b_alu_B_first", opb_b, 32'h1357_9BDF);
        for (int i = 0; i < NVB; i++) begin
            chk1("b_busy_run", busy_b, 1'b1);
            chk1("b_done_run", done_b, 1'b0);
            chk("b_ctrl_seq", {28'b0, ctl_b}, 32'(i % 10));
            @(negedge clk);
        end
        chk1("b_busy_end", busy_b, 1'b0);
        chk1("b_done_end", done_b, 1'b1);
        chk1("b_pass_bad_golden", pass_b, 1'b0);
        chk("b_sig_end", sig_b, SIG_B);
        chk("b_alu_ctrl_done", {28'b0, ctl_b}, 32'h0);

        // Full 256-vector run against the golden signature
        run_a(-1, -1, lat);
        chk("a_latency", lat, NVA + 1);
        chk1("a_pass", pass_a, 1'b1);
        chk("a_sig_golden", sig_a, GOLD_A);
        s0 = sig_a;

        // Restart from DONE repeats bit-identically
        run_a(-1, -1, lat);
        chk("rerun_sig", sig_a, s0);
        chk1("rerun_pass", pass_a, 1'b1);

        // start during RUN is ignored
        run_a(-1, 5, lat);
        chk("midstart_latency", lat, NVA + 1);
        chk("midstart_sig", sig_a, s0);

        // rst at vector 5 aborts; a fresh run still matches
        @(negedge clk);
        st_a = 1'b1;
        @(negedge clk);
        st_a = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk1("abort_busy", busy_a, 1'b0);
        chk1("abort_done", done_a, 1'b0);
        chk1("abort_pass", pass_a, 1'b0);
        chk("abort_sig", sig_a, 32'hFFFF_FFFF);
        run_a(-1, -1, lat);
        chk("after_abort_sig", sig_a, s0);
        chk1("after_abort_pass", pass_a, 1'b1);

`ifdef ALU_BIST_FAULT_INJECT_EN
        run_a(3, -1, lat);
        chk1("inject_pass", pass_a, 1'b0);
        chk1("inject_sig_differs", sig_a != GOLD_A, 1'b1);
`endif

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
